key_event: RTL and testbench
============================

// Module: key_event
// PURPOSE
//   Consumes the debounced level from the upstream 4-tap glitch filter and turns it
//   into one-clock event pulses: press, release, single click, double click, long press.
//   Time is counted in enable ticks, using the same 'en' strobe that drives the filter,
//   so all windows scale with the filter's sample rate.
//   Sits between the filter and the control/register logic that acts on key events.
// PARAMETERS
//   LONG_TICKS  20  en ticks held (from press) before long press fires; legal >= 2
//   DCLK_TICKS   8  en ticks after a short release to wait for a 2nd press; legal >= 1
//   CNT_W        5  tick counter width; 2**CNT_W >= max(LONG_TICKS, DCLK_TICKS)
// PORTS
//   clk     in   1  clock
//   rst_n   in   1  synchronous reset, active low
//   en      in   1  sample tick, same strobe as the upstream filter enable
//   lvl     in   1  debounced key level from filter output y, 1 = pressed
//   press   out  1  pulse, 0->1 edge of lvl accepted
//   rls     out  1  pulse, 1->0 edge of lvl accepted
//   click   out  1  pulse, single short press and release, no 2nd press within window
//   dclick  out  1  pulse, second short press released
//   lpress  out  1  pulse, hold reached LONG_TICKS
//   held    out  1  level, 1 while in LONG state
// BEHAVIOUR
//   - Reset: sync, active-low, wins over en. state=IDLE, cnt=0, all outputs 0.
//   - FSM and cnt advance only on clk edges with en=1. With en=0, state and cnt hold.
//   - Pulse outputs are registered and cleared on every clk edge unless set.
//     Each pulse is exactly 1 clk wide, in the cycle after the en=1 edge that caused it.
//   - held is registered: 1 exactly while state==LONG.
//   - States (all on en=1; lvl compare takes priority over timeout):
//     IDLE : lvl=1 -> DOWN1, cnt<=0, press.
//     DOWN1: lvl=0 -> UP1, cnt<=0, rls.
//            elif cnt==LONG_TICKS-1 -> LONG, lpress.
//            else cnt++.
//     UP1  : lvl=1 -> DOWN2, cnt<=0, press.
//            elif cnt==DCLK_TICKS-1 -> IDLE, click.
//            else cnt++.
//     DOWN2: lvl=0 -> IDLE, rls and dclick in the same cycle.
//            elif cnt==LONG_TICKS-1 -> LONG, lpress (no click or dclick emitted).
//            else cnt++.
//     LONG : lvl=0 -> IDLE, rls. Otherwise stay; no repeat of lpress.
//     Illegal encodings -> IDLE, no pulse.
//   - cnt never exceeds max(LONG_TICKS, DCLK_TICKS)-1. It does not wrap and needs no saturation.
//   - Simultaneous events:
//     lvl edge and timeout on the same tick: the edge wins, so no click or lpress is emitted.
//     dclick and rls assert together. click is never coincident with press.
//   - Reset mid-operation: all pending events are discarded and nothing is emitted.
//     If lvl=1 at the first en tick after reset, IDLE accepts it as a new press.
//   - Press-to-lpress latency: exactly LONG_TICKS en ticks after the tick that emitted press.
// TESTING
//   (LONG_TICKS=20, DCLK_TICKS=8, en=1 every clk unless stated.)
//   1. lvl=1 for 5 ticks, then 0 -> press at t0+1, rls at t5+1; click 8 ticks after the
//      rls tick; no dclick or lpress.
//   2. 3-tick press, 0 for 4 ticks, 3-tick press, release -> press x2, rls x2,
//      dclick with the 2nd rls; no click.
//   3. lvl=1 held for 30 ticks -> lpress 20 ticks after press, held=1 until release,
//      single rls; no click.
//   4. en asserted every 4th clk, lvl=1 held -> lpress after 20 en ticks (80 clk);
//      every pulse is 1 clk wide.
//   5. rst_n=0 for 1 clk while in DOWN1 at cnt=10, lvl stays 1 -> all outputs 0;
//      press re-emitted on the next en tick; lpress 20 ticks after that press.
//   6. Release exactly on the tick where cnt==LONG_TICKS-1 -> rls only, state UP1,
//      no lpress; click follows 8 ticks later.

Source files
------------

// File: rtl/key_event.sv
// key_event: turns a debounced key level into one-clock
// press / release / click / double-click / long-press events.
module key_event #(
  parameter int LONG_TICKS = 20,
  parameter int DCLK_TICKS = 8,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic lvl,
  output logic press,
  output logic rls,
  output logic click,
  output logic dclick,
  output logic lpress,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DOWN1 = 3'd1,
    S_UP1   = 3'd2,
    S_DOWN2 = 3'd3,
    S_LONG  = 3'd4
  } state_t;

  // Last count value before a window expires.
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST =
    CNT_W'(DCLK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic press_q,  press_d;
  logic rls_q,    rls_d;
  logic click_q,  click_d;
  logic dclick_q, dclick_d;
  logic lpress_q, lpress_d;
  logic held_q,   held_d;

  // Next state, tick counter and event pulses.
  // A level change always beats a window timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rls_d    = 1'b0;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    lpress_d = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (lvl) begin
            state_d = S_DOWN1;
            cnt_d   = '0;
            press_d = 1'b1;
          end
        end
        S_DOWN1: begin
          if (!lvl) begin
            state_d = S_UP1;
            cnt_d   = '0;
            rls_d   = 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_d  = S_LONG;
            lpress_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_UP1: begin
          if (lvl) begin
            state_d = S_DOWN2;
            cnt_d   = '0;
            press_d = 1'b1;
          end else if (cnt_q == DCLK_LAST) begin
            state_d = S_IDLE;
            click_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DOWN2: begin
          if (!lvl) begin
            state_d  = S_IDLE;
            rls_d    = 1'b1;
            dclick_d = 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_d  = S_LONG;
            lpress_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_LONG: begin
          if (!lvl) begin
            state_d = S_IDLE;
            rls_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    held_d = (state_d == S_LONG);
  end

  // State, counter and registered outputs; reset wins over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rls_q    <= 1'b0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      lpress_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rls_q    <= rls_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      lpress_q <= lpress_d;
      held_q   <= held_d;
    end
  end

  assign press  = press_q;
  assign rls    = rls_q;
  assign click  = click_q;
  assign dclick = dclick_q;
  assign lpress = lpress_q;
  assign held   = held_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed stimulus with a deadline-based
// event model compared against key_event every cycle.
module tb_key_event;

  localparam int L = 20;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n, en, lvl;
  logic press, rls, click, dclick, lpress, held;

  key_event #(
    .LONG_TICKS(L),
    .DCLK_TICKS(D),
    .CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lvl(lvl),
    .press(press), .rls(rls), .click(click),
    .dclick(dclick), .lpress(lpress), .held(held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic check(string nm, logic [31:0] a,
                       logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, a, e);
    end
  endtask

  // Model: gesture flags plus absolute deadlines in en ticks.
  int n = 0;
  int lp_at = 0;
  int ck_at = 0;
  bit act = 0, dn = 0, sec = 0, lng = 0;
  bit e_press = 0, e_rls = 0, e_click = 0;
  bit e_dclick = 0, e_lpress = 0, e_held = 0;

  always @(posedge clk) begin
    e_press = 0; e_rls = 0; e_click = 0;
    e_dclick = 0; e_lpress = 0;
    if (!rst_n) begin
      act = 0; dn = 0; sec = 0; lng = 0;
    end else if (en) begin
      n++;
      if (!act) begin
        if (lvl) begin
          e_press = 1; act = 1; dn = 1;
          sec = 0; lng = 0; lp_at = n + L;
        end
      end else if (lng) begin
        if (!lvl) begin
          e_rls = 1; act = 0; dn = 0; lng = 0;
        end
      end else if (dn) begin
        if (!lvl) begin
          e_rls = 1; dn = 0;
          if (sec) begin
            e_dclick = 1; act = 0;
          end else begin
            ck_at = n + D;
          end
        end else if (n == lp_at) begin
          e_lpress = 1; lng = 1;
        end
      end else begin
        if (lvl) begin
          e_press = 1; dn = 1; sec = 1;
          lp_at = n + L;
        end else if (n == ck_at) begin
          e_click = 1; act = 0;
        end
      end
    end
    e_held = lng;
  end

  always @(negedge clk) begin
    if (chk_on)
      check("outs",
        {press, rls, click, dclick, lpress, held},
        {e_press, e_rls, e_click,
         e_dclick, e_lpress, e_held});
  end

  // Observed pulse counts and the cycle of the latest pulse.
  int cyc = 0;
  int c_press, c_rls, c_click, c_dclick, c_lpress;
  int y_press, y_rls, y_click, y_dclick, y_lpress;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_on) begin
      if (press === 1'b1)  begin c_press++;  y_press = cyc;  end
      if (rls === 1'b1)    begin c_rls++;    y_rls = cyc;    end
      if (click === 1'b1)  begin c_click++;  y_click = cyc;  end
      if (dclick === 1'b1) begin c_dclick++; y_dclick = cyc; end
      if (lpress === 1'b1) begin c_lpress++; y_lpress = cyc; end
    end
  end

  task automatic clr();
    c_press = 0; c_rls = 0; c_click = 0;
    c_dclick = 0; c_lpress = 0;
    y_press = 0; y_rls = 0; y_click = 0;
    y_dclick = 0; y_lpress = 0;
  endtask

  task automatic drive(logic l, logic e);
    lvl = l;
    en  = e;
    @(negedge clk);
  endtask

  task automatic counts(string t, int p, int r,
                        int c, int d, int lp);
    #1;
    check({t, "_press"},  c_press,  p);
    check({t, "_rls"},    c_rls,    r);
    check({t, "_click"},  c_click,  c);
    check({t, "_dclick"}, c_dclick, d);
    check({t, "_lpress"}, c_lpress, lp);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    en    = 1'b1;
    lvl   = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1;
    #1;
    check("reset_outs",
      {press, rls, click, dclick, lpress, held}, 0);
    rst_n = 1'b1;
    drive(0, 1);
    drive(0, 1);

    // 1: short press, single click
    clr();
    repeat (5)  drive(1, 1);
    repeat (12) drive(0, 1);
    counts("t1", 1, 1, 1, 0, 0);
    check("t1_click_gap", y_click - y_rls, D);
    check("t1_rls_gap", y_rls - y_press, 5);

    // 2: double click
    clr();
    repeat (3)  drive(1, 1);
    repeat (4)  drive(0, 1);
    repeat (3)  drive(1, 1);
    repeat (12) drive(0, 1);
    counts("t2", 2, 2, 0, 1, 0);
    check("t2_dclick_with_rls", y_dclick, y_rls);

    // 3: long hold
    clr();
    repeat (30) drive(1, 1);
    repeat (12) drive(0, 1);
    counts("t3", 1, 1, 0, 0, 1);
    check("t3_lp_lat", y_lpress - y_press, L);

    // 4: en every 4th clock
    clr();
    for (int k = 0; k < 22; k++) begin
      drive(1, 1);
      repeat (3) drive(1, 0);
    end
    drive(0, 1);
    repeat (3) drive(0, 0);
    repeat (4) drive(0, 1);
    counts("t4", 1, 1, 0, 0, 1);
    check("t4_lp_lat", y_lpress - y_press, 4 * L);

    // 5: reset while in DOWN1 with cnt at 10
    clr();
    repeat (11) drive(1, 1);
    rst_n = 1'b0;
    drive(1, 1);
    rst_n = 1'b1;
    #1;
    check("t5_rst_outs",
      {press, rls, click, dclick, lpress, held}, 0);
    repeat (25) drive(1, 1);
    repeat (12) drive(0, 1);
    counts("t5", 2, 1, 0, 0, 1);
    check("t5_lp_lat", y_lpress - y_press, L);

    // 6: release exactly on the timeout tick
    clr();
    repeat (L)  drive(1, 1);
    repeat (12) drive(0, 1);
    counts("t6", 1, 1, 1, 0, 0);
    check("t6_click_gap", y_click - y_rls, D);
    check("t6_rls_gap", y_rls - y_press, L);

    repeat (3) drive(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
